matrix_uart_input_parser: RTL and testbench
===========================================

Name: matrix_uart_input_parser

Overview:
- UART receive-side parser for matrix entry, the counterpart to the text the board sends for matrix listing.
- Consumes ASCII bytes from uart_rx and tokenizes whitespace-separated decimal numbers.
- Token order: row count, column count, then rows*cols elements in row-major order.
- Each element is written into the multi-matrix storage write port. Completion or error is reported to the top-level FSM.

Parameters:
- MAX_SIZE, 5: maximum rows/cols accepted; also the upper bound of the dimension check.
- DATA_WIDTH, 8: element width on wr_data.
- MAX_VAL, 9: largest legal element value.
- TIMEOUT_CYCLES, 100000000: idle-gap limit, used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start_req  in  1  level or pulse; arms the parser when idle
- busy  out  1  high from arm until done/err
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received ASCII byte
- dim_valid  out  1  one-cycle pulse when both dimensions are accepted
- dim_row  out  3  accepted row count
- dim_col  out  3  accepted column count
- wr_en  out  1  one-cycle element write strobe
- wr_row  out  3  element row index, 0-based
- wr_col  out  3  element column index, 0-based
- wr_data  out  DATA_WIDTH  element value
- done  out  1  one-cycle pulse, full matrix received
- err  out  1  one-cycle pulse, parse aborted
- err_code  out  2  valid with err: 00 timeout, 01 illegal char, 10 dimension out of range, 11 element out of range

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0; token-pending flag 0.

Character classes:
- Digit: 0x30-0x39.
- Separator: 0x20, 0x09, 0x0D, 0x0A, 0x2C.
- Anything else is illegal.

Accumulation:
- On a digit: acc <= acc*10 + digit, held in an internal 8-bit register; pending <= 1.
- If acc*10 + digit would exceed 255, set a sticky ovf flag. A token with ovf set is treated as out of range.

Token completion:
- A token completes on the first separator after at least one digit.
- Consecutive separators, and leading separators, are ignored.

State machine: IDLE -> GET_ROWS -> GET_COLS -> GET_ELEM -> IDLE.
- IDLE:
  - busy=0; rx_valid ignored.
  - start_req=1 -> busy<=1, clear acc/pending/ovf/indices, go to GET_ROWS.
- GET_ROWS:
  - On token complete: value in 1..MAX_SIZE -> latch dim_row, go to GET_COLS.
  - Otherwise -> error 10.
- GET_COLS:
  - Same range check. On success, latch dim_col and pulse dim_valid in the next cycle.
  - Row/col indices <= 0; go to GET_ELEM.
- GET_ELEM:
  - On token complete: value > MAX_VAL or ovf -> error 11.
  - Otherwise, in the next cycle: wr_en=1, wr_data=value zero-extended to DATA_WIDTH, wr_row/wr_col=current indices.
  - Index advance: column first; col wraps to 0 at dim_col-1 and row increments.
  - On the write of (dim_row-1, dim_col-1): done pulses in the same cycle as that wr_en, busy<=0, go to IDLE.
- Latency: one clk from the rx_valid of the terminating separator to wr_en/dim_valid/done/err.
- Illegal char in any active state -> error 01.
- Error action: err=1 and err_code for one cycle, busy<=0, no wr_en in that cycle, go to IDLE. Partially written elements are not rolled back.
- start_req while busy: ignored.
- Bytes after done: ignored until re-armed. Bytes following the final separator are not consumed.
- A digit run still pending when the stream stops stays pending; no write occurs. It is recovered only by the optional timeout or by reset.
- rx_valid is never back-to-back faster than 1 per clk. Every byte is processed in its own cycle; no buffering is required.
- Asynchronous reset mid-operation: returns to IDLE immediately; no pulses emitted.

Optional Feature:
- MATRIX_PARSER_TIMEOUT_EN defined:
  - A counter clears on every rx_valid while busy and increments each clk otherwise.
  - Reaching TIMEOUT_CYCLES in GET_ROWS/GET_COLS/GET_ELEM -> err pulse with err_code 00, busy<=0, IDLE.
- Undefined: no counter is present; the parser waits indefinitely; err_code 00 is never produced.

Test Plan:
- Arm, send "2 3\n1 2 3\n4 5 6\n" -> dim_valid with dim_row=2, dim_col=3. Six wr_en pulses: (0,0)=1 ... (1,2)=6. done coincides with the sixth write; busy falls.
- Arm, send "  2,,2\r\n9 0 7 8 " -> extra separators ignored; writes 9,0,7,8 to (0,0),(0,1),(1,0),(1,1); done.
- Arm, send "6 " -> err with code 10, no dim_valid. Arm, send "0 " -> err code 10.
- Arm, send "1 2 3 12 " -> dim_valid, wr (0,0)=3, then err code 11 on "12". Arm, send "1 1 300 " -> err code 11 via ovf.
- Arm, send "2 a" -> err code 01. Assert rst_n low mid-stream -> all outputs 0 immediately; no further pulses.
- With MATRIX_PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=50: send "2 2 1 " then idle -> err code 00 after 50 clks. Without the macro, same stimulus: busy stays 1 and no err.

Source files
------------

// File: rtl/matrix_uart_input_parser.sv
// matrix_uart_input_parser
// Parses an ASCII byte stream from the UART receiver into a matrix. The stream
// holds whitespace/comma separated decimal tokens: row count, column count, then
// rows*cols elements in row-major order. Each element goes out on a one-cycle
// storage write strobe. Completion (done) or an abort (err + err_code) is
// reported to the top-level FSM.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_req            arms the parser while idle (ignored while busy)
//   busy                 high from arm until done/err
//   rx_valid, rx_data    one-cycle received-byte strobe and byte
//   dim_valid            pulse once both dimensions are accepted
//   dim_row, dim_col     accepted dimensions
//   wr_en                element write strobe
//   wr_row, wr_col       0-based element indices
//   wr_data              element value
//   done                 pulse with the last element write
//   err, err_code        abort pulse: 00 timeout, 01 illegal char,
//                        10 dimension out of range, 11 element out of range
//
// Optional: define MATRIX_PARSER_TIMEOUT_EN to abort with code 00 after
// TIMEOUT_CYCLES clocks without a received byte while busy.
module matrix_uart_input_parser #(
  parameter int unsigned MAX_SIZE       = 5,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_VAL        = 9,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_req,
  output logic                  busy,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  dim_valid,
  output logic [2:0]            dim_row,
  output logic [2:0]            dim_col,
  output logic                  wr_en,
  output logic [2:0]            wr_row,
  output logic [2:0]            wr_col,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {StIdle, StGetRows, StGetCols, StGetElem} state_e;

  localparam logic [1:0] ErrTimeout = 2'b00;
  localparam logic [1:0] ErrChar    = 2'b01;
  localparam logic [1:0] ErrDim     = 2'b10;
  localparam logic [1:0] ErrElem    = 2'b11;

  state_e                state_q, state_d;
  logic [7:0]            acc_q, acc_d;
  logic                  pend_q, pend_d, ovf_q, ovf_d;
  logic [2:0]            row_idx_q, row_idx_d, col_idx_q, col_idx_d;
  logic [2:0]            dim_row_q, dim_row_d, dim_col_q, dim_col_d;
  logic                  busy_q, busy_d, dim_valid_q, dim_valid_d;
  logic                  wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
  logic [2:0]            wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            err_code_q, err_code_d;

  logic        is_digit, is_sep;
  logic [11:0] acc_mac;
  logic        fail;
  logic [1:0]  fail_code;
  logic        dim_ok;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep   = rx_data inside {8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
  // Worst case 255*10+9 fits in 12 bits, so the overflow test is exact.
  assign acc_mac  = {4'b0, acc_q} * 12'd10 + {8'b0, rx_data[3:0]};
  assign dim_ok   = !ovf_q && (acc_q >= 8'd1) && (acc_q <= 8'(MAX_SIZE));

`ifdef MATRIX_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (busy_q && !rx_valid) tmo_d = tmo_q + TmoW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    dim_row_d   = dim_row_q;
    dim_col_d   = dim_col_q;
    busy_d      = busy_q;
    dim_valid_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = 2'b00;
    fail        = 1'b0;
    fail_code   = ErrChar;

    if (state_q == StIdle) begin
      if (start_req) begin
        busy_d    = 1'b1;
        acc_d     = '0;
        pend_d    = 1'b0;
        ovf_d     = 1'b0;
        row_idx_d = '0;
        col_idx_d = '0;
        state_d   = StGetRows;
      end
    end else if (rx_valid) begin
      if (is_digit) begin
        acc_d  = acc_mac[7:0];
        pend_d = 1'b1;
        if (acc_mac > 12'd255) ovf_d = 1'b1;
      end else if (!is_sep) begin
        fail      = 1'b1;
        fail_code = ErrChar;
      end else if (pend_q) begin
        acc_d  = '0;
        pend_d = 1'b0;
        ovf_d  = 1'b0;
        unique case (state_q)
          StGetRows: begin
            if (dim_ok) begin
              dim_row_d = acc_q[2:0];
              state_d   = StGetCols;
            end else begin
              fail      = 1'b1;
              fail_code = ErrDim;
            end
          end
          StGetCols: begin
            if (dim_ok) begin
              dim_col_d   = acc_q[2:0];
              dim_valid_d = 1'b1;
              row_idx_d   = '0;
              col_idx_d   = '0;
              state_d     = StGetElem;
            end else begin
              fail      = 1'b1;
              fail_code = ErrDim;
            end
          end
          default: begin
            if (ovf_q || (acc_q > 8'(MAX_VAL))) begin
              fail      = 1'b1;
              fail_code = ErrElem;
            end else begin
              wr_en_d   = 1'b1;
              wr_row_d  = row_idx_q;
              wr_col_d  = col_idx_q;
              wr_data_d = DATA_WIDTH'(acc_q);
              if (col_idx_q == dim_col_q - 3'd1) begin
                col_idx_d = '0;
                if (row_idx_q == dim_row_q - 3'd1) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
                end else begin
                  row_idx_d = row_idx_q + 3'd1;
                end
              end else begin
                col_idx_d = col_idx_q + 3'd1;
              end
            end
          end
        endcase
      end
    end
`ifdef MATRIX_PARSER_TIMEOUT_EN
    else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      fail      = 1'b1;
      fail_code = ErrTimeout;
    end
`endif

    if (fail) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
      busy_d     = 1'b0;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      dim_row_q   <= '0;
      dim_col_q   <= '0;
      busy_q      <= 1'b0;
      dim_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      dim_row_q   <= dim_row_d;
      dim_col_q   <= dim_col_d;
      busy_q      <= busy_d;
      dim_valid_q <= dim_valid_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy      = busy_q;
  assign dim_valid = dim_valid_q;
  assign dim_row   = dim_row_q;
  assign dim_col   = dim_col_q;
  assign wr_en     = wr_en_q;
  assign wr_row    = wr_row_q;
  assign wr_col    = wr_col_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_matrix_uart_input_parser.sv
// Scoreboard bench for matrix_uart_input_parser: directed byte strings push
// their hand-computed output pulses into a queue; a negedge monitor pops and
// compares every cycle that shows dim_valid, wr_en, done or err.
module tb_matrix_uart_input_parser;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_req = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          busy, dim_valid, wr_en, done, err;
  logic [2:0]    dim_row, dim_col, wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic [1:0]    err_code;

  matrix_uart_input_parser #(
    .MAX_SIZE      (5),
    .DATA_WIDTH    (DW),
    .MAX_VAL       (9),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_req(start_req),
    .busy     (busy),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .dim_valid(dim_valid),
    .dim_row  (dim_row),
    .dim_col  (dim_col),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // {dim_valid, dim_row, dim_col, wr_en, wr_row, wr_col, wr_data, done, err, err_code}
  typedef logic [25:0] ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input logic dv, input logic [2:0] dr, input logic [2:0] dc,
                             input logic we, input logic [2:0] r, input logic [2:0] c,
                             input logic [7:0] d, input logic dn, input logic er,
                             input logic [1:0] ec);
    return {dv, dr, dc, we, r, c, d, dn, er, ec};
  endfunction

  function automatic void exp_dim(input logic [2:0] r, input logic [2:0] c);
    exp_q.push_back(mk(1'b1, r, c, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 2'd0));
  endfunction

  function automatic void exp_wr(input logic [2:0] r, input logic [2:0] c,
                                 input logic [7:0] d, input logic dn);
    exp_q.push_back(mk(1'b0, 3'd0, 3'd0, 1'b1, r, c, d, dn, 1'b0, 2'd0));
  endfunction

  function automatic void exp_err(input logic [1:0] code);
    exp_q.push_back(mk(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b1, code));
  endfunction

  always @(negedge clk) begin
    ev_t obs;
    ev_t want;
    if (dim_valid || wr_en || done || err) begin
      obs = mk(dim_valid, dim_valid ? dim_row : 3'd0, dim_valid ? dim_col : 3'd0,
               wr_en, wr_en ? wr_row : 3'd0, wr_en ? wr_col : 3'd0,
               wr_en ? 8'(wr_data) : 8'd0, done, err, err ? err_code : 2'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%h want=none", obs);
      end else begin
        want = exp_q.pop_front();
        if (obs !== want) begin
          errors++;
          $display("FAIL pulse got=%h want=%h", obs, want);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic arm();
    @(posedge clk);
    #1;
    start_req = 1'b1;
    @(posedge clk);
    #1;
    start_req = 1'b0;
  endtask

  // Bounded wait for every queued pulse to be seen.
  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, busy, dim_valid, dim_row, dim_col, wr_en, wr_row, wr_col, 8'(wr_data),
            done, err, err_code};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    tick(2);

    // 2x3 matrix
    arm();
    check("busy_after_arm", busy, 1);
    exp_dim(3'd2, 3'd3);
    exp_wr(0, 0, 1, 0); exp_wr(0, 1, 2, 0); exp_wr(0, 2, 3, 0);
    exp_wr(1, 0, 4, 0); exp_wr(1, 1, 5, 0); exp_wr(1, 2, 6, 1);
    send_str("2 3\n1 2 3\n4 5 6\n");
    drain("drain_2x3");
    check("busy_after_done_2x3", busy, 0);

    // extra and leading separators
    arm();
    exp_dim(3'd2, 3'd2);
    exp_wr(0, 0, 9, 0); exp_wr(0, 1, 0, 0); exp_wr(1, 0, 7, 0); exp_wr(1, 1, 8, 1);
    send_str("  2,,2\015\n9 0 7 8 ");
    drain("drain_seps");
    check("busy_after_done_seps", busy, 0);

    // dimension out of range, both ends
    arm();
    exp_err(2'b10);
    send_str("6 ");
    drain("drain_dim6");
    check("busy_after_dim6", busy, 0);
    arm();
    exp_err(2'b10);
    send_str("0 ");
    drain("drain_dim0");

    // element out of range, by value and by overflow
    arm();
    exp_dim(3'd1, 3'd2);
    exp_wr(0, 0, 3, 0);
    exp_err(2'b11);
    send_str("1 2 3 12 ");
    drain("drain_elem12");
    arm();
    exp_dim(3'd1, 3'd1);
    exp_err(2'b11);
    send_str("1 1 300 ");
    drain("drain_elem300");

    // illegal character
    arm();
    exp_err(2'b01);
    send_str("2 a");
    drain("drain_illegal");
    check("busy_after_illegal", busy, 0);

    // MAX_SIZE rows, single column, MAX_VAL element, tab separator
    arm();
    exp_dim(3'd5, 3'd1);
    exp_wr(0, 0, 0, 0); exp_wr(1, 0, 1, 0); exp_wr(2, 0, 2, 0);
    exp_wr(3, 0, 3, 0); exp_wr(4, 0, 9, 1);
    send_str("5\t1 0 1 2 3 9\n");
    drain("drain_5x1");

    // bytes while idle are ignored
    send_str("1 1 5 ");
    tick(3);
    check("busy_idle_bytes", busy, 0);

    // idle gap after a partial matrix
    arm();
    exp_dim(3'd2, 3'd2);
    exp_wr(0, 0, 1, 0);
`ifdef MATRIX_PARSER_TIMEOUT_EN
    exp_err(2'b00);
`endif
    send_str("2 2 1 ");
    tick(60);
    drain("drain_gap");
`ifdef MATRIX_PARSER_TIMEOUT_EN
    check("busy_after_timeout", busy, 0);
`else
    check("busy_during_gap", busy, 1);
    // re-arm while busy must not restart the parse
    arm();
    exp_wr(0, 1, 5, 0); exp_wr(1, 0, 6, 0); exp_wr(1, 1, 7, 1);
    send_str("5 6 7 ");
    drain("drain_resume");
    check("busy_after_resume", busy, 0);
`endif

    // asynchronous reset mid-stream, with a terminating separator in flight
    arm();
    exp_dim(3'd2, 3'd2);
    exp_wr(0, 0, 1, 0);
    send_str("2 2 1 5");
    drain("drain_pre_reset");
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h20;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tick(2);
    check("held_reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    tick(2);
    send_str(" 3 ");
    tick(3);
    check("after_reset_outputs", all_outs(), 0);

    check("queue_empty_final", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
